pipe_skid_reg: RTL
==================

# pipe_skid_reg

- Elastic 2-entry pipeline register with a valid/ready handshake on both sides; default width is 8 bits.
- It is the consumer-side counterpart of the plain capture register: a plain flop loads on every clock, while this block takes a word only on a handshake and holds it until the downstream side takes it.
- It sits between fetch and decode, and at any other stage boundary where the reader may stall.
- It gives one word per cycle throughput with registered `in_ready`, so no combinational ready path runs upstream.

## Interface

Parameters:
- `WIDTH`, default 8: width of the data word.

Ports:
- `clk`, input, 1: the single clock. Every action happens on the rising edge.
- `reset`, input, 1: synchronous, active-high. It is sampled only on the rising edge of `clk`.
- `flush`, input, 1: synchronous discard of all held words.
- `in_valid`, input, 1: the producer has a word on `in_data`.
- `in_ready`, output, 1: the block can accept a word. This output is registered.
- `in_data`, input, WIDTH: the producer's word.
- `out_valid`, output, 1: `out_data` holds a valid word. This output is registered.
- `out_ready`, input, 1: the consumer takes the word this cycle.
- `out_data`, output, WIDTH: the oldest held word. Driven directly from the main register.
- `count`, output, 2: number of words held (0, 1 or 2).

## Operation

Transfer definitions:
- Input transfer (in_xfer) = `in_valid && in_ready`.
- Output transfer (out_xfer) = `out_valid && out_ready`.

Storage:
- Main register: drives `out_data`.
- Skid register: holds the overflow word when the consumer stalls.

States (encoded in the shared package):
- EMPTY: `count`=0.
- BUSY: `count`=1.
- FULL: `count`=2.

Transitions, evaluated on each rising edge:
- EMPTY, in_xfer: main <= `in_data`; go to BUSY.
- BUSY, in_xfer and out_xfer: main <= `in_data`; stay in BUSY.
- BUSY, in_xfer only: skid <= `in_data`; go to FULL.
- BUSY, out_xfer only: go to EMPTY.
- FULL, out_xfer: main <= skid; go to BUSY. `in_ready` is 0 in FULL, so there is no input transfer.
- Any state, no transfer: hold.

Registered outputs:
- `out_valid` = (state != EMPTY).
- `in_ready` = (state != FULL).
- Both are computed from the next state and registered.

Ordering and data rules:
- Words leave in strict FIFO order. No word is duplicated or lost.
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- In EMPTY, `out_data` holds the last value. Downstream must ignore it.
- `in_valid` with `in_ready`=0 has no effect. The producer keeps the word on `in_data` until it is accepted.

Priority, highest first: `reset`, `flush`, normal transfers.
- `flush`:
  - Next state is EMPTY, so `out_valid`=0 and `in_ready`=1 on the next cycle.
  - Main and skid registers keep their contents.
  - If `in_ready`=1 during a flush cycle, an offered word counts as accepted and is discarded.
  - A word presented with `out_ready`=1 during a flush cycle counts as consumed.
- `reset`: overrides everything, including a transfer in the same cycle.

## Timing

Reset values (one cycle after `reset` is sampled high):
- `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=0.
- Skid register = 0; state = EMPTY.

Latency and throughput:
- Latency: a word accepted at edge N is on `out_data` with `out_valid`=1 after edge N, available to the consumer in cycle N+1.
- Throughput: one word per cycle sustained while `out_ready`=1.

Stall and recovery:
- `in_ready` falls one cycle after the stall that fills the skid register.
- `in_ready` rises in the cycle after FULL drains to BUSY.
- When `out_ready` goes low, at most one extra word is accepted; it lands in the skid register.

Reset during operation:
- Held words are lost.
- No transfer is reported on either side during the reset cycle.

## Structure

- Package `pipe_pkg` holds:
  - the state enum `skid_state_t` (EMPTY, BUSY, FULL);
  - the constant `SKID_DEPTH = 2`.
- The package will be shared by later pipeline-stage blocks.
- One sub-module, `skid_slot`: a WIDTH-bit register with synchronous active-high reset and load enable. Instantiate it twice, once for main and once for skid.
- The state machine and handshake logic stay in the top module.

## Test plan

- Reset, then idle: after the reset edge, `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=8'h00.
- Streaming: with `out_ready`=1, offer 8'h11, 8'h22, 8'h33 on consecutive cycles. Required: the same values appear on `out_data` one cycle later with no bubbles, and `count` stays at 1.
- Stall fill:
  - In BUSY holding 8'hA0, drop `out_ready` and offer 8'hA1, then 8'hA2.
  - Required: 8'hA1 is accepted, `count`=2, `in_ready`=0, and 8'hA2 is held off.
  - Raise `out_ready`. Required output order: A0, A1, then A2.
- Simultaneous transfer in BUSY: in_xfer and out_xfer in the same cycle. Required: `count` stays 1 and `out_data` takes the new word next cycle.
- Flush while FULL: assert `flush` for one cycle. Required next cycle: `out_valid`=0, `in_ready`=1, `count`=0, and a following 8'h5C passes through normally.
- Reset mid-stall while FULL with `in_valid`=1. Required: the block returns to reset values, and the offered word is not accepted during the reset cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage blocks.
package pipe_pkg;

  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Number of words held in a given occupancy state.
  function automatic logic [1:0] state_count(input skid_state_t s);
    logic [1:0] c;
    case (s)
      EMPTY:   c = 2'd0;
      BUSY:    c = 2'd1;
      FULL:    c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_skid_slot.sv
// One data-word storage slot with synchronous reset and load enable.
module skid_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Storage flop: cleared on reset, loaded only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register: main slot drives out_data, skid slot
// absorbs the one word accepted while the consumer stalls.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      r_state;
  skid_state_t      w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld;
  logic             w_skid_ld;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next-state and slot-load decode; flush empties without touching slot data.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_ld        = 1'b0;
    w_skid_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_main_ld   = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
        BUSY: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_ld   = 1'b1;
            w_state_nxt = BUSY;
          end else if (w_in_xfer) begin
            w_skid_ld   = 1'b1;
            w_state_nxt = FULL;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
          end else begin
            w_state_nxt = BUSY;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            w_main_ld        = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = BUSY;
          end else begin
            w_state_nxt = FULL;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Main slot refills from skid when draining FULL, otherwise from the producer.
  always_comb begin
    if (w_main_from_skid) begin
      w_main_d = w_skid_q;
    end else begin
      w_main_d = in_data;
    end
  end

  skid_slot #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_main_ld),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  skid_slot #(.WIDTH(WIDTH)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_skid_ld),
    .i_d    (in_data),
    .o_q    (w_skid_q)
  );

  // State and handshake flags, all registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_count     <= state_count(w_state_nxt);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign count     = r_count;

endmodule
